// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : store_buffer
// Description : Posted-write FIFO between the core data port and data memory.
//               Stores are captured in order and drained over a valid/ready
//               handshake. The core is stalled only when the buffer is full
//               and the head is not draining in the same cycle.
//               Optional macro STORE_BUF_FWD_EN builds the word-granular
//               load-forwarding lookup (youngest matching pending store).
//               Without it rd_hit/rd_data are tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       memwrite,
    input  logic [AW-1:0]              dataadr,
    input  logic [DW-1:0]              writedata,
    output logic                       stall,
    output logic                       mem_valid,
    output logic [AW-1:0]              mem_addr,
    output logic [DW-1:0]              mem_wdata,
    input  logic                       mem_ready,
    input  logic [AW-1:0]              rd_addr,
    output logic                       rd_hit,
    output logic [DW-1:0]              rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

    logic [AW-1:0] r_addr [DEPTH];
    logic [DW-1:0] r_data [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    logic w_full;
    logic w_push;
    logic w_pop;

    assign w_full    = (r_count == C_FULL);
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign mem_valid = !empty;
    assign mem_addr  = r_addr[r_rptr];
    assign mem_wdata = r_data[r_rptr];

    // A full buffer can still accept a store when the head drains this cycle.
    assign stall  = memwrite && w_full && !mem_ready;
    assign w_push = memwrite && !stall && !reset;
    assign w_pop  = mem_valid && mem_ready;

    // Entry storage; contents need no reset because occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_wptr] <= dataadr;
            r_data[r_wptr] <= writedata;
        end
    end

    // Pointers and occupancy; reset discards pending entries without draining.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef STORE_BUF_FWD_EN
    // Entries are examined by age: age 0 is the head (oldest).
    logic [PW-1:0]    w_age_idx [DEPTH];
    logic [DEPTH-1:0] w_age_hit;
    logic             w_unused_rd_lsb;

    // Byte offset is ignored: matching is at word granularity.
    assign w_unused_rd_lsb = ^rd_addr[1:0];

    for (genvar k = 0; k < DEPTH; k++) begin : g_age
        assign w_age_idx[k] = r_rptr + PW'(k);
        assign w_age_hit[k] = (CW'(k) < r_count) &&
                              (r_addr[w_age_idx[k]][AW-1:2] == rd_addr[AW-1:2]);
    end

    // Youngest match wins: later (younger) ages override earlier ones.
    always_comb begin
        rd_hit  = 1'b0;
        rd_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (w_age_hit[k]) begin
                rd_hit  = 1'b1;
                rd_data = r_data[w_age_idx[k]];
            end
        end
    end
`else
    logic w_unused_rd;

    // Lookup port kept for interface stability; no comparators are built.
    assign w_unused_rd = ^rd_addr;
    assign rd_hit      = 1'b0;
    assign rd_data     = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_store_buffer
// Description : Self-checking bench for store_buffer: a directed vector table
//               covering reset, single store, full/stall, simultaneous
//               push/pop, forwarding and mid-operation reset, followed by
//               randomized traffic compared against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_store_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk;
    logic          reset;
    logic          memwrite;
    logic [AW-1:0] dataadr;
    logic [DW-1:0] writedata;
    logic          stall;
    logic          mem_valid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready;
    logic [AW-1:0] rd_addr;
    logic          rd_hit;
    logic [DW-1:0] rd_data;
    logic [CW-1:0] count;
    logic          empty;

    int errors = 0;
    int checks = 0;

    store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .dataadr   (dataadr),
        .writedata (writedata),
        .stall     (stall),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .rd_addr   (rd_addr),
        .rd_hit    (rd_hit),
        .rd_data   (rd_data),
        .count     (count),
        .empty     (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef STORE_BUF_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    // Directed vector: inputs applied before an edge, expected outputs seen
    // before that same edge (state from earlier edges, combinational now).
    typedef struct {
        logic        chk;
        logic        rst;
        logic        mw;
        logic [31:0] adr;
        logic [31:0] wd;
        logic        rdy;
        logic [31:0] ra;
        logic        e_stall;
        logic        e_valid;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        int          e_count;
        logic        e_hit;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vq[$];

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    ent_t model[$];

    task automatic add(input logic chk, input logic rst, input logic mw,
                       input logic [31:0] adr, input logic [31:0] wd,
                       input logic rdy, input logic [31:0] ra,
                       input logic e_stall, input logic e_valid,
                       input logic [31:0] e_addr, input logic [31:0] e_wdata,
                       input int e_count, input logic e_hit,
                       input logic [31:0] e_rdata);
        vec_t v;
        v.chk = chk; v.rst = rst; v.mw = mw; v.adr = adr; v.wd = wd;
        v.rdy = rdy; v.ra = ra; v.e_stall = e_stall; v.e_valid = e_valid;
        v.e_addr = e_addr; v.e_wdata = e_wdata; v.e_count = e_count;
        v.e_hit = e_hit; v.e_rdata = e_rdata;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d (0x%0h), expected %0d (0x%0h)",
                     name, $time, act, act, exp, exp);
        end
    endtask

    // Compare every output against one set of expectations.
    task automatic check_all(input string tag, input logic e_stall,
                             input logic e_valid, input logic [31:0] e_addr,
                             input logic [31:0] e_wdata, input int e_count,
                             input logic e_hit, input logic [31:0] e_rdata);
        check({tag, ".stall"}, 32'(stall), 32'(e_stall));
        check({tag, ".mem_valid"}, 32'(mem_valid), 32'(e_valid));
        check({tag, ".count"}, 32'(count), 32'(e_count));
        check({tag, ".empty"}, 32'(empty), 32'(e_count == 0));
        if (e_valid) begin
            check({tag, ".mem_addr"}, mem_addr, e_addr);
            check({tag, ".mem_wdata"}, mem_wdata, e_wdata);
        end
        check({tag, ".rd_hit"}, 32'(rd_hit), 32'(e_hit && FWD));
        check({tag, ".rd_data"}, rd_data, FWD ? e_rdata : 32'd0);
    endtask

    initial begin
        reset = 1'b1; memwrite = 1'b0; dataadr = '0; writedata = '0;
        mem_ready = 1'b0; rd_addr = '0;

        //   chk rst mw adr  wd  rdy ra    stall vld addr wdat cnt hit rdata
        // Reset held 2 cycles with a store presented: it must be ignored.
        add(0, 1, 1,  84,  7, 0,  0,   0, 0,   0,  0, 0, 0, 0);
        add(1, 1, 1,  84,  7, 0,  0,   0, 0,   0,  0, 0, 0, 0);
        add(1, 0, 0,   0,  0, 0,  0,   0, 0,   0,  0, 0, 0, 0);
        // Single store, then one drain cycle.
        add(1, 0, 1,  84,  7, 0,  0,   0, 0,   0,  0, 0, 0, 0);
        add(1, 0, 0,   0,  0, 0,  0,   0, 1,  84,  7, 1, 0, 0);
        add(1, 0, 0,   0,  0, 1,  0,   0, 1,  84,  7, 1, 0, 0);
        add(1, 0, 0,   0,  0, 0,  0,   0, 0,   0,  0, 0, 0, 0);
        // Fill to DEPTH, stall, then push+pop while full.
        add(1, 0, 1,  80,  1, 0,  0,   0, 0,   0,  0, 0, 0, 0);
        add(1, 0, 1,  84,  2, 0,  0,   0, 1,  80,  1, 1, 0, 0);
        add(1, 0, 1,  88,  3, 0,  0,   0, 1,  80,  1, 2, 0, 0);
        add(1, 0, 1,  92,  4, 0,  0,   0, 1,  80,  1, 3, 0, 0);
        add(1, 0, 1,  96,  5, 0,  0,   1, 1,  80,  1, 4, 0, 0);
        add(1, 0, 1,  96,  5, 1,  0,   0, 1,  80,  1, 4, 0, 0);
        add(1, 0, 0,   0,  0, 1,  0,   0, 1,  84,  2, 4, 0, 0);
        add(1, 0, 0,   0,  0, 1,  0,   0, 1,  88,  3, 3, 0, 0);
        add(1, 0, 0,   0,  0, 1,  0,   0, 1,  92,  4, 2, 0, 0);
        add(1, 0, 0,   0,  0, 1,  0,   0, 1,  96,  5, 1, 0, 0);
        add(1, 0, 0,   0,  0, 0,  0,   0, 0,   0,  0, 0, 0, 0);
        // Forwarding: two stores to word 80; the store being pushed is excluded.
        add(1, 0, 1,  80,  5, 0, 80,   0, 0,   0,  0, 0, 0, 0);
        add(1, 0, 1,  80,  9, 0, 80,   0, 1,  80,  5, 1, 1, 5);
        add(1, 0, 0,   0,  0, 0, 80,   0, 1,  80,  5, 2, 1, 9);
        add(1, 0, 0,   0,  0, 0, 83,   0, 1,  80,  5, 2, 1, 9);
        add(1, 0, 0,   0,  0, 0, 84,   0, 1,  80,  5, 2, 0, 0);
        add(1, 0, 0,   0,  0, 1, 80,   0, 1,  80,  5, 2, 1, 9);
        add(1, 0, 0,   0,  0, 1, 80,   0, 1,  80,  9, 1, 1, 9);
        add(1, 0, 0,   0,  0, 0, 80,   0, 0,   0,  0, 0, 0, 0);
        // Reset with 3 entries pending; old entries must never drain.
        add(1, 0, 1, 100, 11, 0,  0,   0, 0,   0,  0, 0, 0, 0);
        add(1, 0, 1, 104, 12, 0,  0,   0, 1, 100, 11, 1, 0, 0);
        add(1, 0, 1, 108, 13, 0,  0,   0, 1, 100, 11, 2, 0, 0);
        add(1, 1, 0,   0,  0, 0,  0,   0, 1, 100, 11, 3, 0, 0);
        add(1, 0, 0,   0,  0, 0,  0,   0, 0,   0,  0, 0, 0, 0);
        add(1, 0, 1, 200, 21, 0,  0,   0, 0,   0,  0, 0, 0, 0);
        add(1, 0, 0,   0,  0, 1,  0,   0, 1, 200, 21, 1, 0, 0);
        add(1, 0, 0,   0,  0, 0,  0,   0, 0,   0,  0, 0, 0, 0);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            reset = vq[i].rst; memwrite = vq[i].mw; dataadr = vq[i].adr;
            writedata = vq[i].wd; mem_ready = vq[i].rdy; rd_addr = vq[i].ra;
            #2;
            if (vq[i].chk)
                check_all($sformatf("vec%0d", i), vq[i].e_stall, vq[i].e_valid,
                          vq[i].e_addr, vq[i].e_wdata, vq[i].e_count,
                          vq[i].e_hit, vq[i].e_rdata);
        end

        // Clear the DUT so the model starts from a known empty state.
        @(negedge clk);
        reset = 1'b1; memwrite = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model.delete();

        // Randomized traffic against a queue model of the buffer.
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic        e_stall;
            logic        e_hit;
            logic [31:0] e_rdata;
            logic [31:0] ha;
            logic [31:0] hd;
            @(negedge clk);
            reset     = ($urandom_range(0, 99) < 2);
            memwrite  = ($urandom_range(0, 99) < 70);
            dataadr   = 32'($urandom_range(16, 23)) * 4 + 32'($urandom_range(0, 3));
            writedata = $urandom;
            mem_ready = ($urandom_range(0, 99) < 45);
            rd_addr   = 32'($urandom_range(16, 23)) * 4 + 32'($urandom_range(0, 3));
            #2;
            e_stall = memwrite && (model.size() == DEPTH) && !mem_ready;
            e_hit   = 1'b0;
            e_rdata = '0;
            for (int j = model.size() - 1; j >= 0; j--) begin
                if (model[j].a[31:2] == rd_addr[31:2]) begin
                    e_hit   = 1'b1;
                    e_rdata = model[j].d;
                    break;
                end
            end
            ha = (model.size() > 0) ? model[0].a : 32'd0;
            hd = (model.size() > 0) ? model[0].d : 32'd0;
            check_all($sformatf("rnd%0d", cyc), e_stall, model.size() > 0,
                      ha, hd, model.size(), e_hit, e_rdata);
            @(posedge clk);
            if (reset) begin
                model.delete();
            end else begin
                if (model.size() > 0 && mem_ready) void'(model.pop_front());
                if (memwrite && !e_stall) begin
                    ent_t e;
                    e.a = dataadr;
                    e.d = writedata;
                    model.push_back(e);
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
